// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: X = A + B*conj(W), Y = A - B*conj(W), Q8.8 twiddles,
// three-stage pipeline that freezes as a whole under output backpressure.
module fft_butterfly_r2 #(
  parameter int N     = 16,
  parameter int FRAC  = 8,
  parameter int SCALE = 1,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic signed [N-1:0] a_re,
  input  logic signed [N-1:0] a_im,
  input  logic signed [N-1:0] b_re,
  input  logic signed [N-1:0] b_im,
  input  logic [2:0]          tw_idx,
  input  logic [8*N-1:0]      tw_re_bus,
  input  logic [8*N-1:0]      tw_im_bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic signed [N-1:0] x_re,
  output logic signed [N-1:0] x_im,
  output logic signed [N-1:0] y_re,
  output logic signed [N-1:0] y_im
);

  localparam int W2 = 2 * N;
  localparam int WS = N + 2;
  localparam logic signed [W2:0] RND = (W2+1)'(2 ** (FRAC - 1));

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // stage 1
  logic                v1;
  logic [TAG_W-1:0]    tag1;
  logic signed [N-1:0] ar1, ai1, br1, bi1, tr1, ti1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      tag1 <= '0;
      ar1  <= '0;
      ai1  <= '0;
      br1  <= '0;
      bi1  <= '0;
      tr1  <= '0;
      ti1  <= '0;
    end else if (en) begin
      v1   <= in_valid;
      tag1 <= in_tag;
      ar1  <= a_re;
      ai1  <= a_im;
      br1  <= b_re;
      bi1  <= b_im;
      tr1  <= tw_re_bus[tw_idx*N +: N];
      ti1  <= tw_im_bus[tw_idx*N +: N];
    end
  end

  // stage 2
  logic                 v2;
  logic [TAG_W-1:0]     tag2;
  logic signed [N-1:0]  ar2, ai2;
  logic signed [W2-1:0] rr, ii, ir, ri;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      tag2 <= '0;
      ar2  <= '0;
      ai2  <= '0;
      rr   <= '0;
      ii   <= '0;
      ir   <= '0;
      ri   <= '0;
    end else if (en) begin
      v2   <= v1;
      tag2 <= tag1;
      ar2  <= ar1;
      ai2  <= ai1;
      rr   <= W2'(br1) * W2'(tr1);
      ii   <= W2'(bi1) * W2'(ti1);
      ir   <= W2'(bi1) * W2'(tr1);
      ri   <= W2'(br1) * W2'(ti1);
    end
  end

  // stage 3 combine: round P to N+1 bits, add/sub at N+2 bits, scale, saturate
  function automatic logic signed [N-1:0] sat(input logic signed [WS-1:0] v);
    if (v[WS-1:N-1] == '0 || v[WS-1:N-1] == '1)
      sat = v[N-1:0];
    else if (v[WS-1])
      sat = {1'b1, {(N-1){1'b0}}};
    else
      sat = {1'b0, {(N-1){1'b1}}};
  endfunction

  logic signed [W2:0]   sum_re, sum_im;
  logic signed [N:0]    p_re, p_im;
  logic signed [WS-1:0] sx_re, sx_im, sy_re, sy_im;

  always_comb begin
    sum_re = (W2+1)'(rr) + (W2+1)'(ii) + RND;
    sum_im = (W2+1)'(ir) - (W2+1)'(ri) + RND;
    p_re   = (N+1)'(sum_re >>> FRAC);
    p_im   = (N+1)'(sum_im >>> FRAC);
    sx_re  = WS'(ar2) + WS'(p_re);
    sx_im  = WS'(ai2) + WS'(p_im);
    sy_re  = WS'(ar2) - WS'(p_re);
    sy_im  = WS'(ai2) - WS'(p_im);
    if (SCALE != 0) begin
      sx_re = sx_re >>> 1;
      sx_im = sx_im >>> 1;
      sy_re = sy_re >>> 1;
      sy_im = sy_im >>> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
    end else if (en) begin
      out_valid <= v2;
      out_tag   <= tag2;
      x_re      <= sat(sx_re);
      x_im      <= sat(sx_im);
      y_re      <= sat(sy_re);
      y_im      <= sat(sy_im);
    end
  end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2: one SCALE=1 and one SCALE=0 instance
// share the same stimulus; each test checks the instance it targets.
module tb_fft_butterfly_r2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               in_valid, out_ready;
  logic [3:0]         in_tag;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic [2:0]         tw_idx;
  logic [127:0]       tw_re_bus, tw_im_bus;

  logic               rdy1, ov1, rdy0, ov0;
  logic [3:0]         ot1, ot0;
  logic signed [15:0] x1r, x1i, y1r, y1i, x0r, x0i, y0r, y0i;

  fft_butterfly_r2 #(.N(16), .FRAC(8), .SCALE(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_tag(in_tag),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
    .tw_re_bus(tw_re_bus), .tw_im_bus(tw_im_bus), .out_valid(ov1), .out_ready(out_ready),
    .out_tag(ot1), .x_re(x1r), .x_im(x1i), .y_re(y1r), .y_im(y1i)
  );

  fft_butterfly_r2 #(.N(16), .FRAC(8), .SCALE(0), .TAG_W(4)) dut0 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_tag(in_tag),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
    .tw_re_bus(tw_re_bus), .tw_im_bus(tw_im_bus), .out_valid(ov0), .out_ready(out_ready),
    .out_tag(ot0), .x_re(x0r), .x_im(x0i), .y_re(y0r), .y_im(y0i)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int tg, input int idx, input int ar, input int ai,
                       input int br, input int bi);
    in_valid = 1'b1;
    in_tag   = 4'(tg);
    tw_idx   = 3'(idx);
    a_re     = 16'(ar);
    a_im     = 16'(ai);
    b_re     = 16'(br);
    b_im     = 16'(bi);
  endtask

  // one item through the selected instance, checking exact 3-cycle latency
  task automatic run_one(input string nm, input int sel, input int tg, input int idx,
                         input int ar, input int ai, input int br, input int bi,
                         input int exr, input int exi, input int eyr, input int eyi);
    logic [15:0] saved;
    @(negedge clk);
    drive(tg, idx, ar, ai, br, bi);
    #1 check({nm, ".in_ready"}, sel != 0 ? rdy1 : rdy0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    saved = tw_re_bus[idx*16 +: 16];
    tw_re_bus[idx*16 +: 16] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    #1 check({nm, ".early_valid"}, sel != 0 ? ov1 : ov0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({nm, ".valid"}, sel != 0 ? ov1 : ov0, 1);
    check({nm, ".tag"},   sel != 0 ? ot1 : ot0, tg);
    check({nm, ".x_re"},  sel != 0 ? x1r : x0r, exr);
    check({nm, ".x_im"},  sel != 0 ? x1i : x0i, exi);
    check({nm, ".y_re"},  sel != 0 ? y1r : y0r, eyr);
    check({nm, ".y_im"},  sel != 0 ? y1i : y0i, eyi);
    tw_re_bus[idx*16 +: 16] = saved;
  endtask

  int re_tab[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int im_tab[8] = '{0, 98, 181, 237, 256, 237, 181, 98};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsent, nrcv, held_tag, held_x, was_stalled;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tw_re_bus[k*16 +: 16] = 16'(re_tab[k]);
      tw_im_bus[k*16 +: 16] = 16'(im_tab[k]);
    end
    #12;
    check("reset.out_valid", ov1, 0);
    check("reset.in_ready", rdy1, 1);
    check("reset.out_tag", ot1, 0);
    check("reset.x_re", x1r, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("ident",  1, 3,  0, 256, 0, 256, 0, 256, 0, 0, 0);
    run_one("tw45",   1, 6,  2, 0, 0, 256, 0, 90, -91, -91, 90);
    run_one("twj",    0, 12, 4, 0, 0, 256, 0, 0, -256, 0, 256);
    run_one("sat",    0, 15, 0, 32767, 0, 256, 0, 32767, 0, 32511, 0);
    run_one("satneg", 0, 1,  0, -32768, 0, -256, 0, -32768, 0, -32512, 0);

    // backpressure: 8 items, stalls at cycles 4..8 and 10..11 (single release at 9)
    nsent = 0;
    nrcv = 0;
    held_tag = 0;
    held_x = 0;
    was_stalled = 0;
    for (int cyc = 0; cyc < 60 && nrcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !((cyc >= 4 && cyc <= 8) || (cyc >= 10 && cyc <= 11));
      #1;
      if (!out_ready && ov1) begin
        check("bp.in_ready_low", rdy1, 0);
        if (was_stalled != 0) begin
          check("bp.hold_tag", ot1, held_tag);
          check("bp.hold_x_re", x1r, held_x);
        end
        held_tag = ot1;
        held_x = x1r;
      end
      if (ov1 && out_ready) begin
        check("bp.tag_order", ot1, nrcv);
        check("bp.x_re", x1r, 50 * nrcv + 128);
        check("bp.y_re", y1r, 50 * nrcv - 128);
        nrcv++;
      end
      if (nsent < 8) begin
        drive(nsent, 0, 100 * nsent, nsent, 256, 0);
        if (rdy1) nsent++;
      end else begin
        in_valid = 1'b0;
      end
      was_stalled = out_ready ? 0 : 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp.count", nrcv, 8);

    // reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(9 + i, 0, 256, 0, 256, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("rst.preload_valid", ov1, 1);
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", ov1, 0);
    check("rst.out_valid0", ov0, 0);
    check("rst.in_ready", rdy1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("rst.no_stale", ov1, 0);
    run_one("after_rst", 1, 5, 0, 256, 0, 256, 0, 256, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
